// File: rtl/cpu65_bus_trace.sv
// cpu65_bus_trace: samples completed cpu65 bus cycles through an
// arm/trigger/length state machine and an optional opcode-fetch filter.
// It packs each accepted cycle into a 32-bit record and buffers the records
// in a first-word-fall-through FIFO, which is drained over a valid/ready port.
// Record layout: {seq[3:0], SYNC, RWn, VPn, MLn, D[7:0], A[15:0]}.
module cpu65_bus_trace #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bus_strobe_i,
  input  logic [15:0]                bus_a_i,
  input  logic [7:0]                 bus_d_i,
  input  logic                       bus_rwn_i,
  input  logic                       bus_sync_i,
  input  logic                       bus_vpn_i,
  input  logic                       bus_mln_i,
  input  logic                       arm_i,
  input  logic                       abort_i,
  input  logic                       trig_any_i,
  input  logic [15:0]                trig_addr_i,
  input  logic                       sync_only_i,
  input  logic [7:0]                 cap_len_i,
  output logic [31:0]                rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [1:0]                 state_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    seq_q, seq_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH];

  logic          qual_s;
  logic          trig_hit_s;
  logic [7:0]    cnt_inc_s;
  logic          limit_hit_s;
  logic          flush_s;
  logic          wr_try_s;
  logic          wr_ok_s;
  logic          rd_fire_s;
  logic [31:0]   rec_s;

  // Strobe qualification, trigger match and capture-limit detection.
  assign qual_s      = bus_strobe_i && (!sync_only_i || bus_sync_i);
  assign trig_hit_s  = qual_s && (trig_any_i || (bus_sync_i && (bus_a_i == trig_addr_i)));
  assign cnt_inc_s   = cnt_q + 8'd1;
  assign limit_hit_s = (cap_len_i != 8'd0) && (cnt_inc_s == cap_len_i);
  // Abort has priority over arm, so a simultaneous pair never flushes.
  assign flush_s     = arm_i && !abort_i;
  assign rd_fire_s   = (level_q != {LW{1'b0}}) && rd_ready_i;
  assign rec_s       = {seq_q, bus_sync_i, bus_rwn_i, bus_vpn_i, bus_mln_i, bus_d_i, bus_a_i};

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort, then arm, then trigger/limit progression.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else if (arm_i) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (trig_hit_s) begin
            state_d = limit_hit_s ? ST_DONE : ST_CAPTURE;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (qual_s && limit_hit_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_IDLE:  state_d = ST_IDLE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: decide whether this cycle's strobe is a record candidate.
  always_comb begin
    wr_try_s = 1'b0;
    if (abort_i || arm_i) begin
      wr_try_s = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED:   wr_try_s = trig_hit_s;
        ST_CAPTURE: wr_try_s = qual_s;
        ST_IDLE:    wr_try_s = 1'b0;
        ST_DONE:    wr_try_s = 1'b0;
        default:    wr_try_s = 1'b0;
      endcase
    end
  end

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_ok_s = wr_try_s && ((level_q != LW'(DEPTH)) || rd_fire_s);

  // Next-state for pointers, occupancy, sequence, capture count and overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    if (flush_s) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {LW{1'b0}};
      ovf_d    = 1'b0;
      seq_d    = 4'd0;
      cnt_d    = 8'd0;
    end else begin
      if (rd_fire_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (wr_ok_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      level_d = level_q + LW'(wr_ok_s) - LW'(rd_fire_s);
      if (wr_try_s) begin
        // Seq and count advance even for a dropped record so gaps are visible.
        seq_d = seq_q + 4'd1;
        cnt_d = cnt_inc_s;
        ovf_d = ovf_q || !wr_ok_s;
      end else begin
        seq_d = seq_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
      ovf_q    <= 1'b0;
      seq_q    <= 4'd0;
      cnt_q    <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
    end
  end

  // Record storage; contents are meaningless while level is zero.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s && !rst_i) begin
      mem_q[wr_ptr_q] <= rec_s;
    end
  end

  assign rd_valid_o = (level_q != {LW{1'b0}});
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : 32'd0;
  assign state_o    = state_q;
  assign overflow_o = ovf_q;
  assign level_o    = level_q;

endmodule

// File: doc/cpu65_bus_trace.md
# cpu65_bus_trace

Bus-cycle trace capture that sits directly downstream of the `cpu65` core in the IsaBench harness. It samples every completed CPU bus cycle (address, data, RWn, SYNC, VPn, MLn), applies an arm/trigger/length state machine and an optional opcode-fetch filter, and buffers 32-bit records in a FIFO. A bench or host drains the FIFO over a valid/ready port. Its purpose is instruction-flow and bus-cycle checking without per-cycle scraping of the debug outputs.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `clk_i`  in  1  system clock; the same clock that drives the CPU's PH0IN
- `rst_i`  in  1  reset, synchronous, active-high
- `bus_strobe_i`  in  1  one-cycle pulse; a CPU bus cycle completed and the bus inputs are valid
- `bus_a_i`  in  16  address bus
- `bus_d_i`  in  8  data bus: write data when `bus_rwn_i`=0, read data otherwise
- `bus_rwn_i`, `bus_sync_i`, `bus_vpn_i`, `bus_mln_i`  in  1 each  CPU cycle qualifiers
- `arm_i`  in  1  pulse; start a new trace
- `abort_i`  in  1  pulse; stop the trace
- `trig_any_i`  in  1  1 = trigger on the first qualifying strobe after arming
- `trig_addr_i`  in  16  trigger address; matches on a SYNC cycle only
- `sync_only_i`  in  1  1 = record only cycles with SYNC=1
- `cap_len_i`  in  8  number of records to take; 0 = unlimited
- `rd_data_o`  out  32  head record; first-word-fall-through; 0 when the FIFO is empty
- `rd_valid_o`  out  1  FIFO is non-empty
- `rd_ready_i`  in  1  consumer accepts the head record
- `state_o`  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- `overflow_o`  out  1  sticky; at least one record was dropped
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- **Record format:**
  - [31:28] seq
  - [27] SYNC, [26] RWn, [25] VPn, [24] MLn
  - [23:16] D
  - [15:0] A
- **Qualifying strobe:** `bus_strobe_i`=1 and (`sync_only_i`=0 or SYNC=1).
- **IDLE:** ignores the bus.
- **`arm_i` (any state):**
  - next state ARMED
  - flushes the FIFO; level=0
  - clears `overflow_o`, seq and the capture count
- **ARMED:** a qualifying strobe with `trig_any_i`=1, or with SYNC=1 and A==`trig_addr_i`:
  - goes to CAPTURE
  - records the triggering cycle as the first record
- **CAPTURE:** every qualifying strobe attempts a write.
  - The capture count increments per qualifying strobe, dropped or not.
  - When the count reaches `cap_len_i` (≠0), go to DONE. The strobe that hits the limit is recorded.
- **DONE:** ignores the bus. The FIFO remains readable.
- **`abort_i`:** next state IDLE; FIFO contents are kept. When `abort_i` and `arm_i` are asserted together, abort wins.
- **Seq:** 4 bits, increments on every qualifying strobe in CAPTURE (including the trigger), wraps 15→0. A gap in seq shows dropped records.
- **FIFO:**
  - A write happens when level<DEPTH, or when level==DEPTH and a read fires in the same cycle. Otherwise the record is dropped and `overflow_o` is set.
  - Simultaneous read and write: level is unchanged.
  - Pointers wrap modulo DEPTH.
- **Read:** a read fires when `rd_valid_o`&&`rd_ready_i`. `rd_ready_i` has no effect when the FIFO is empty.
- **`cap_len_i`, `trig_*`, `sync_only_i`:** sampled live. They are stable while ARMED/CAPTURE by contract.

## Timing
- **Reset values:** state IDLE, `rd_valid_o`=0, `rd_data_o`=0, `overflow_o`=0, `level_o`=0, seq=0, capture count=0.
- **Reset mid-capture:** returns to IDLE with the FIFO emptied on the next edge.
- **Write latency:** a strobe recorded at edge t appears on `rd_data_o`/`rd_valid_o` after edge t (1 cycle) when the FIFO was empty. Otherwise it is visible when it reaches the head.
- **State changes:**
  - ARMED→CAPTURE happens on the edge that samples the trigger strobe.
  - CAPTURE→DONE happens on the edge that samples the limit strobe. A strobe in the next cycle is not recorded.
- **After a read:** `rd_data_o` updates to the next entry on the same edge.
- **Level:** `level_o` and `overflow_o` are registered and update on the edge of the write/read.
- **Throughput:** one strobe per cycle is sustained.

## Test plan
- **Basic capture:**
  - Stimulus: reset; arm with `trig_any_i`=1, `cap_len_i`=3; drive 4 strobes A=0x0200..0x0203, D=0xA9, RWn=1, SYNC=1.
  - Response: 3 records; seq 0,1,2; the 4th strobe is ignored; state_o=3.
- **Address trigger:**
  - Stimulus: `trig_addr_i`=0xC000; SYNC strobes at 0xBFFE, 0xC000, 0xC001.
  - Response: the first record has A=0xC000, seq=0; 0xBFFE is absent.
- **Opcode-fetch filter:**
  - Stimulus: `sync_only_i`=1; strobes with SYNC pattern 1,0,0,1, `cap_len_i`=0.
  - Response: 2 records, seq 0,1; level_o=2.
- **Overflow:**
  - Stimulus: DEPTH=16, no reads; 18 qualifying strobes.
  - Response: level_o=16; overflow_o=1; record seq runs 0..15.
  - Follow-up: with full+strobe+read in the same cycle, the strobe is accepted and level stays 16.
- **Wrap and drain:**
  - Stimulus: 20 strobes with `rd_ready_i`=1 held.
  - Response: all 20 read in order; seq wraps 15→0→3; no overflow; pointers wrap cleanly.
- **Abort and re-arm:**
  - Stimulus: abort mid-CAPTURE.
  - Response: state_o=0; FIFO retained. Re-arm: FIFO empty, overflow_o=0, seq restarts at 0.
  - Stimulus: `arm_i` and `abort_i` in the same cycle.
  - Response: IDLE.
